// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
// Holds the loader state encoding and the word-index to byte-address mapping.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN
  } loader_state_t;

  // IM words are 32-bit, so a word index becomes a byte offset by shifting left 2.
  localparam int unsigned WORD_SHIFT = 2;

  function automatic logic [31:0] word_to_byte(input logic [31:0] base,
                                               input logic [31:0] idx);
    return base + (idx << WORD_SHIFT);
  endfunction

endpackage

// File: rtl/rst_release_timer.sv
// Core-reset release timer: counts out the HOLD interval once the loader enters HOLD.
// expire is high in the cycle the count sits at 1, so the FSM leaves HOLD on the next edge.
module rst_release_timer #(
  parameter int unsigned RELEASE_DLY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = (RELEASE_DLY < 1) ? 1 : $clog2(RELEASE_DLY + 1);
  localparam logic [CNT_W-1:0] DLY_VAL = CNT_W'(RELEASE_DLY);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // Zero means "not yet armed": the first enabled edge loads the delay, later edges count down.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= DLY_VAL;
    end else begin
      cnt <= cnt - ONE;
    end
  end

  assign expire = en && (cnt == ONE);

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: streams program words into IM at consecutive
// addresses while holding the core in reset, then releases it after a fixed delay.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter logic [31:0] IM_BASE     = 32'h0000_0000,
  parameter int unsigned RELEASE_DLY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              im_we,
  output logic [31:0]       im_addr,
  output logic [31:0]       im_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum,
  output logic              err
);

  localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

  loader_state_t     state;
  loader_state_t     state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_nxt;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_nxt;
  logic [31:0]       checksum_nxt;
  logic              err_nxt;
  logic              accept;
  logic              count_ok;
  logic              last_word;
  logic              timer_expire;

  assign accept    = in_valid & in_ready;
  assign count_ok  = (num_words != '0) && (num_words <= MAX_WORDS);
  assign last_word = ({1'b0, idx} == (count - CNT_ONE));

  rst_release_timer #(
    .RELEASE_DLY(RELEASE_DLY)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (state == HOLD),
    .expire (timer_expire)
  );

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    count_nxt    = count;
    checksum_nxt = checksum;
    err_nxt      = err;
    unique case (state)
      IDLE, RUN: begin
        if (start) begin
          if (count_ok) begin
            state_nxt    = LOAD;
            idx_nxt      = '0;
            count_nxt    = num_words;
            checksum_nxt = '0;
            err_nxt      = 1'b0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      LOAD: begin
        // A start here is rejected even when it coincides with the final word.
        if (start) begin
          err_nxt = 1'b1;
        end
        if (accept) begin
          checksum_nxt = checksum ^ in_data;
          idx_nxt      = idx + IDX_ONE;
          if (last_word) begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (start) begin
          err_nxt = 1'b1;
        end
        if (timer_expire) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      checksum <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      core_rst <= 1'b1;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      checksum <= checksum_nxt;
      err      <= err_nxt;
      done     <= (state_nxt == RUN);
      busy     <= (state_nxt == LOAD) || (state_nxt == HOLD);
      core_rst <= (state_nxt != RUN);
      in_ready <= (state_nxt == LOAD);
    end
  end

  always_ff @(posedge clk) begin
    count <= count_nxt;
  end

  assign im_we    = accept;
  assign im_addr  = word_to_byte(IM_BASE, 32'(idx));
  assign im_wdata = in_data;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W=2 so the full-depth case is reachable).
module tb_imem_loader;

  localparam int unsigned ADDR_W      = 2;
  localparam int unsigned RELEASE_DLY = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   num_words = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_data = '0;
  logic              im_we;
  logic [31:0]       im_addr;
  logic [31:0]       im_wdata;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic [31:0]       checksum;
  logic              err;

  imem_loader #(
    .ADDR_W      (ADDR_W),
    .IM_BASE     (32'h0),
    .RELEASE_DLY (RELEASE_DLY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_words (num_words),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .core_rst  (core_rst),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum),
    .err       (err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          fall_cyc = -1;
  logic        prev_core_rst = 1'b1;
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  int          wr_cyc  [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write and core_rst-fall observer; cycle numbers refer to the posedge that follows/precedes.
  always @(negedge clk) begin
    if (im_we) begin
      wr_addr.push_back(im_addr);
      wr_data.push_back(im_wdata);
      wr_cyc.push_back(cyc + 1);
    end
    if (prev_core_rst && !core_rst) fall_cyc <= cyc;
    prev_core_rst <= core_rst;
  end

  typedef struct {
    logic [ADDR_W:0] nw;
    logic            exp_err;
    logic            exp_busy;
  } start_vec_t;

  start_vec_t vecs [5];

  logic [31:0] prog [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic do_start(input logic [ADDR_W:0] n);
    start = 1'b1;
    num_words = n;
    step();
    start = 1'b0;
  endtask

  // Presents one word and returns two time units after the edge that accepted it.
  task automatic send_word(input logic [31:0] w);
    bit got = 1'b0;
    in_valid = 1'b1;
    in_data = w;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
    if (got) step();
    else check("accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_data = $urandom;
      step();
    end
  endtask

  task automatic wait_run();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    step();
    if (!seen) check("run_timeout", 32'(seen), 32'd1);
  endtask

  initial begin
    int base;
    logic [31:0] exp_cks;

    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h1234_5678;

    vecs[0] = '{nw: 3'd0, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[1] = '{nw: 3'd1, exp_err: 1'b0, exp_busy: 1'b1};
    vecs[2] = '{nw: 3'd4, exp_err: 1'b0, exp_busy: 1'b1};
    vecs[3] = '{nw: 3'd5, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[4] = '{nw: 3'd7, exp_err: 1'b1, exp_busy: 1'b0};

    // Reset values
    repeat (2) step();
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_im_we",    32'(im_we),    32'd0);
    check("rst_err",      32'(err),      32'd0);
    check("rst_checksum", checksum,      32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    rst = 1'b0;

    // Start acceptance from IDLE across the num_words range
    for (int i = 0; i < 5; i++) begin
      apply_reset();
      do_start(vecs[i].nw);
      check($sformatf("vec%0d_err", i),      32'(err),      32'(vecs[i].exp_err));
      check($sformatf("vec%0d_busy", i),     32'(busy),     32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_busy));
    end

    // Basic 3-word load and release timing
    apply_reset();
    base = wr_addr.size();
    do_start(3'd3);
    check("basic_core_rst_load", 32'(core_rst), 32'd1);
    for (int i = 0; i < 3; i++) send_word(prog[i]);
    in_valid = 1'b0;
    check("basic_in_ready_drop", 32'(in_ready), 32'd0);
    check("basic_busy_hold", 32'(busy), 32'd1);
    wait_run();
    check("basic_nwrites", 32'(wr_addr.size() - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("basic_addr%0d", i), wr_addr[base+i], 32'(i * 4));
      check($sformatf("basic_data%0d", i), wr_data[base+i], prog[i]);
    end
    check("basic_checksum", checksum, 32'h00D0_8033);
    check("basic_release_dly", 32'(fall_cyc - wr_cyc[base+2]), 32'(RELEASE_DLY + 1));
    check("basic_done", 32'(done), 32'd1);
    check("basic_core_rst_run", 32'(core_rst), 32'd0);
    check("basic_busy_run", 32'(busy), 32'd0);

    // Reload from RUN with 2-cycle stalls between words
    base = wr_addr.size();
    do_start(3'd3);
    check("reload_core_rst", 32'(core_rst), 32'd1);
    check("reload_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      send_word(prog[i]);
      if (i < 2) stall(2);
    end
    in_valid = 1'b0;
    wait_run();
    check("stall_nwrites", 32'(wr_addr.size() - base), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("stall_addr%0d", i), wr_addr[base+i], 32'(i * 4));
    check("stall_gap01", 32'(wr_cyc[base+1] - wr_cyc[base]), 32'd3);
    check("stall_gap12", 32'(wr_cyc[base+2] - wr_cyc[base+1]), 32'd3);
    check("stall_checksum", checksum, prog[0] ^ prog[1] ^ prog[2]);

    // Full depth with in_valid held high past the last word
    base = wr_addr.size();
    do_start(3'd4);
    for (int i = 0; i < 4; i++) send_word(prog[i]);
    in_data = 32'hDEAD_BEEF;
    repeat (3) step();
    check("full_in_ready_after", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_run();
    check("full_nwrites", 32'(wr_addr.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("full_addr%0d", i), wr_addr[base+i], 32'(i * 4));
    check("full_checksum", checksum, prog[0] ^ prog[1] ^ prog[2] ^ prog[3]);

    // Error handling
    apply_reset();
    do_start(3'd0);
    check("err_zero_err", 32'(err), 32'd1);
    check("err_zero_busy", 32'(busy), 32'd0);
    check("err_zero_core_rst", 32'(core_rst), 32'd1);
    base = wr_addr.size();
    do_start(3'd2);
    check("err_clear_on_start", 32'(err), 32'd0);
    send_word(prog[0]);
    in_valid = 1'b0;
    do_start(3'd3);
    check("err_midload_err", 32'(err), 32'd1);
    check("err_midload_busy", 32'(busy), 32'd1);
    send_word(prog[1]);
    in_valid = 1'b0;
    wait_run();
    check("err_midload_nwrites", 32'(wr_addr.size() - base), 32'd2);
    check("err_midload_checksum", checksum, prog[0] ^ prog[1]);
    check("err_sticky", 32'(err), 32'd1);
    do_start(3'd0);
    check("err_run_bad_err", 32'(err), 32'd1);
    check("err_run_bad_done", 32'(done), 32'd1);
    check("err_run_bad_core_rst", 32'(core_rst), 32'd0);
    do_start(3'd1);
    check("err_run_good_err", 32'(err), 32'd0);
    check("err_run_good_core_rst", 32'(core_rst), 32'd1);
    // start coincident with the final word
    base = wr_addr.size();
    in_valid = 1'b1;
    in_data = prog[2];
    start = 1'b1;
    num_words = 3'd2;
    step();
    start = 1'b0;
    in_valid = 1'b0;
    check("coinc_err", 32'(err), 32'd1);
    check("coinc_in_ready", 32'(in_ready), 32'd0);
    check("coinc_busy", 32'(busy), 32'd1);
    wait_run();
    check("coinc_nwrites", 32'(wr_addr.size() - base), 32'd1);
    check("coinc_checksum", checksum, prog[2]);

    // Reset in the middle of a load
    do_start(3'd3);
    send_word(prog[0]);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_checksum", checksum, 32'd0);
    check("midrst_core_rst", 32'(core_rst), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    base = wr_addr.size();
    in_valid = 1'b1;
    in_data = prog[1];
    repeat (2) step();
    in_valid = 1'b0;
    check("midrst_no_write", 32'(wr_addr.size() - base), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
